// File: rtl/formal_output_checker.sv
// formal_output_checker: compares NUM_CH fabric output channels against reference outputs
//   clk          checker clock, compare sampled on rising edge
//   rst_n        asynchronous active-low reset
//   i_start      begin or restart a check run (ignored while busy)
//   i_abort      end the current run immediately (ignored when not busy)
//   i_dut_out    fabric outputs, channel i = bits [i*WIDTH +: WIDTH]
//   i_ref_out    reference outputs, same packing
//   i_ref_valid  per-bit check enable, 0 = don't-care
//   o_mismatch   registered per-channel mismatch flags
//   o_err_count  saturating count of mismatching channel-cycles
//   o_first_ch   channel of the first mismatch (lowest index on tie)
//   o_first_cyc  check-cycle index of the first mismatch
//   o_busy       run in progress (warm-up or check)
//   o_done       run finished, held until the next start
//   o_pass       done with no errors and not aborted
//   o_aborted    run was ended by abort
module formal_output_checker #(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 1,
    parameter int WARMUP_CYCLES = 1,
    parameter int RUN_CYCLES    = 0,
    parameter int CNT_W         = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            i_start,
    input  logic                                            i_abort,
    input  logic [NUM_CH*WIDTH-1:0]                         i_dut_out,
    input  logic [NUM_CH*WIDTH-1:0]                         i_ref_out,
    input  logic [NUM_CH*WIDTH-1:0]                         i_ref_valid,
    output logic [NUM_CH-1:0]                               o_mismatch,
    output logic [CNT_W-1:0]                                o_err_count,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  o_first_ch,
    output logic [CNT_W-1:0]                                o_first_cyc,
    output logic                                            o_busy,
    output logic                                            o_done,
    output logic                                            o_pass,
    output logic                                            o_aborted
);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POPW = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CHECK, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_found;
    logic [NUM_CH-1:0] w_mm;
    logic [POPW-1:0]  w_pop;
    logic [CHW-1:0]   w_low;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_err_next;

    assign o_busy = (r_state == S_WARMUP) || (r_state == S_CHECK);

    // Descending loop so the last hit written is the lowest mismatching channel.
    always_comb begin
        w_mm  = '0;
        w_pop = '0;
        w_low = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_mm[i] = |((i_dut_out[i*WIDTH +: WIDTH] ^ i_ref_out[i*WIDTH +: WIDTH]) & i_ref_valid[i*WIDTH +: WIDTH]);
            w_pop   = w_pop + POPW'(w_mm[i]);
            if (w_mm[i]) w_low = CHW'(i);
        end
        w_sum      = {1'b0, o_err_count} + (CNT_W+1)'(w_pop);
        w_err_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_found     <= 1'b0;
            o_mismatch  <= '0;
            o_err_count <= '0;
            o_first_ch  <= '0;
            o_first_cyc <= '0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_aborted   <= 1'b0;
        end else begin
            o_mismatch <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= (WARMUP_CYCLES == 0) ? S_CHECK : S_WARMUP;
                        r_cnt       <= '0;
                        r_found     <= 1'b0;
                        o_err_count <= '0;
                        o_first_ch  <= '0;
                        o_first_cyc <= '0;
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_aborted   <= 1'b0;
                    end
                end
                S_WARMUP: begin
                    if (i_abort) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_aborted <= 1'b1;
                    end else if (r_cnt == W_LAST) begin
                        r_state <= S_CHECK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    // An aborted cycle's compare is dropped entirely.
                    if (i_abort) begin
                        r_state   <= S_DONE;
                        o_done    <= 1'b1;
                        o_aborted <= 1'b1;
                    end else begin
                        o_mismatch  <= w_mm;
                        o_err_count <= w_err_next;
                        if (!r_found && |w_mm) begin
                            r_found     <= 1'b1;
                            o_first_ch  <= w_low;
                            o_first_cyc <= r_cnt;
                        end
                        if (RUN_CYCLES != 0 && r_cnt == R_LAST) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                            o_pass  <= (w_err_next == '0);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_formal_output_checker.sv
// tb_formal_output_checker: directed table-driven bench for formal_output_checker
module tb_formal_output_checker;
    logic        clk, rst_n, start, abort, s_start, s_abort;
    logic [3:0]  dut_v, ref_v, val_v;
    logic [3:0]  mm, s_mm;
    logic [15:0] err, fcyc;
    logic [3:0]  s_err, s_fcyc;
    logic [1:0]  fch, s_fch;
    logic        busy, done, pass, aborted;
    logic        s_busy, s_done, s_pass, s_aborted;

    typedef struct {
        logic [3:0] d;
        logic [3:0] r;
        logic [3:0] v;
        logic [3:0] mm;
    } vec_t;

    vec_t        tbl[16];
    logic [1:0]  end_ch[2];
    logic [15:0] end_cyc[2];
    logic [15:0] exp_err;
    int          n_chk, n_fail;

    formal_output_checker #(.NUM_CH(4), .WIDTH(1), .WARMUP_CYCLES(1), .RUN_CYCLES(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dut_out(dut_v), .i_ref_out(ref_v), .i_ref_valid(val_v),
        .o_mismatch(mm), .o_err_count(err), .o_first_ch(fch), .o_first_cyc(fcyc),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_aborted(aborted)
    );

    formal_output_checker #(.NUM_CH(4), .WIDTH(1), .WARMUP_CYCLES(1), .RUN_CYCLES(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_abort(s_abort),
        .i_dut_out(dut_v), .i_ref_out(ref_v), .i_ref_valid(val_v),
        .o_mismatch(s_mm), .o_err_count(s_err), .o_first_ch(s_fch), .o_first_cyc(s_fcyc),
        .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_aborted(s_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Start pulse, one warm-up cycle driving ref^wd, returns at the negedge where check cycle 0 inputs go.
    task automatic start_run(input logic [3:0] wd);
        @(negedge clk);
        start = 1'b1;
        dut_v = ref_v;
        val_v = 4'hF;
        @(negedge clk);
        start = 1'b0;
        dut_v = ref_v ^ wd;
        @(negedge clk);
        dut_v = ref_v;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0; s_abort = 1'b0;
        dut_v = 4'h0; ref_v = 4'h0; val_v = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tbl[k]     = '{4'b1010 ^ ((k == 3 || k == 5) ? 4'b0100 : 4'b0000), 4'b1010, 4'hF,
                           (k == 3 || k == 5) ? 4'b0100 : 4'b0000};
            tbl[8 + k] = '{~4'(k), 4'(k), 4'b1101, 4'b1101};
        end
        end_ch[0] = 2'd2; end_cyc[0] = 16'd3;
        end_ch[1] = 2'd0; end_cyc[1] = 16'd0;

        repeat (2) @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_mm", mm, 0);
        chk("rst_flags", {busy, done, pass, aborted}, 0);
        chk("rst_first", {fch, fcyc}, 0);
        rst_n = 1'b1;

        // clean run: done exactly 1+8 cycles after start
        ref_v = 4'b0110;
        start_run(4'h0);
        chk("busy_run", busy, 1);
        repeat (7) @(negedge clk);
        chk("done_early", done, 0);
        @(negedge clk);
        chk("clean_done", {done, pass, aborted, busy}, 4'b1100);
        chk("clean_err", err, 0);

        // table runs: single-channel errors, then masked channel 1
        for (int k = 0; k < 16; k++) begin
            if (k % 8 == 0) begin
                start_run(4'h0);
                exp_err = 0;
            end
            dut_v = tbl[k].d; ref_v = tbl[k].r; val_v = tbl[k].v;
            @(negedge clk);
            exp_err += 16'($countones(tbl[k].mm));
            chk("tbl_mm", mm, tbl[k].mm);
            chk("tbl_err", err, exp_err);
            if (k % 8 == 7) begin
                chk("tbl_done", {done, pass, aborted}, 3'b100);
                chk("tbl_first_ch", fch, end_ch[k/8]);
                chk("tbl_first_cyc", fcyc, end_cyc[k/8]);
            end
        end

        // abort at check cycle 2 with a mismatch on that cycle
        ref_v = 4'b0011; val_v = 4'hF;
        start_run(4'h0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        dut_v = ~ref_v;
        @(negedge clk);
        abort = 1'b0;
        dut_v = ref_v;
        chk("abort_flags", {done, aborted, pass, busy}, 4'b1100);
        chk("abort_err", err, 0);
        chk("abort_mm", mm, 0);
        start_run(4'h0);
        chk("restart_clear", {done, aborted, busy}, 3'b001);
        chk("restart_err", err, 0);
        // abort and start together while busy: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("both_busy", {done, aborted, busy}, 3'b110);
        // abort and start together while done: start wins
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("both_done", {done, aborted, busy}, 3'b001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // mismatch during warm-up only
        ref_v = 4'b1100;
        start_run(4'hF);
        repeat (8) @(negedge clk);
        chk("warm_pass", {done, pass, aborted}, 3'b110);
        chk("warm_err", err, 0);

        // saturation on the 4-bit counter, unbounded run
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        dut_v = ~ref_v; val_v = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("sat_err", s_err, (4 * i > 15) ? 15 : 4 * i);
        end
        chk("sat_busy", {s_busy, s_done}, 2'b10);
        s_abort = 1'b1;
        @(negedge clk);
        s_abort = 1'b0;
        chk("sat_abort", {s_done, s_aborted, s_pass, s_err}, {3'b110, 4'd15});

        // reset mid-check
        dut_v = ref_v;
        start_run(4'h0);
        dut_v = ~ref_v;
        repeat (2) @(negedge clk);
        chk("pre_rst_err", err, 8);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_err", err, 0);
        chk("midrst_mm", mm, 0);
        chk("midrst_flags", {busy, done, pass, aborted}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {busy, done, err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
